// File: rtl/token_drop_ctrl.sv
// token_drop_ctrl: owns the board, cursor and turn; animates a falling token,
// lands it, then hands newrow/newcolumn to the victory checker.
module token_drop_ctrl #(
  parameter int NROWS      = 8,
  parameter int NCOLS      = 8,
  parameter int FALL_TICKS = 2500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               drop,
  input  logic [6:0]         winner,
  output logic [15:0][15:0]  red,
  output logic [15:0][15:0]  grn,
  output logic [4:0]         newrow,
  output logic [4:0]         newcolumn,
  output logic [3:0]         cursor_col,
  output logic               turn_grn,
  output logic               fall_valid,
  output logic [3:0]         fall_row,
  output logic               busy,
  output logic               game_over,
  output logic               draw
);
  localparam logic [2:0]  IDLE = 3'd0, FALL = 3'd1, LAND = 3'd2, CHECK = 3'd3, WIN = 3'd4, DRAW = 3'd5;
  localparam logic [3:0]  LAST_ROW  = 4'(NROWS - 1);
  localparam logic [3:0]  LAST_COL  = 4'(NCOLS - 1);
  localparam logic [3:0]  MID_COL   = 4'(NCOLS / 2);
  localparam logic [31:0] LAST_TICK = 32'(FALL_TICKS - 1);
  localparam logic [15:0] COL_MASK  = 16'((1 << NCOLS) - 1);
  logic [2:0]        state_q, state_d;
  logic [15:0][15:0] red_q, red_d, grn_q, grn_d, occ;
  logic [3:0]        cur_q, cur_d, col_q, col_d, row_q, row_d, nxt_row;
  logic [4:0]        newrow_q, newrow_d, newcol_q, newcol_d;
  logic              turn_q, turn_d, fv_q, fv_d;
  logic [31:0]       cnt_q, cnt_d;
  assign occ     = red_q | grn_q;
  assign nxt_row = row_q + 4'd1;
  always_comb begin
    state_d  = state_q;
    red_d    = red_q;
    grn_d    = grn_q;
    cur_d    = cur_q;
    col_d    = col_q;
    row_d    = row_q;
    newrow_d = newrow_q;
    newcol_d = newcol_q;
    turn_d   = turn_q;
    fv_d     = fv_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (drop) begin
          if (!occ[0][cur_q]) begin
            row_d   = 4'd0;
            fv_d    = 1'b1;
            cnt_d   = 32'd0;
            col_d   = cur_q;
            state_d = FALL;
          end
        end else if (move_left ^ move_right) begin
          cur_d = move_left ? ((cur_q == 4'd0) ? LAST_COL : cur_q - 4'd1)
                            : ((cur_q == LAST_COL) ? 4'd0 : cur_q + 4'd1);
        end
      end
      FALL: begin
        if (cnt_q != LAST_TICK) cnt_d = cnt_q + 32'd1;
        else if (row_q == LAST_ROW || occ[nxt_row][col_q]) state_d = LAND;
        else begin
          row_d = nxt_row;
          cnt_d = 32'd0;
        end
      end
      LAND: begin
        if (turn_q) grn_d[row_q][col_q] = 1'b1;
        else red_d[row_q][col_q] = 1'b1;
        newrow_d = {1'b0, row_q};
        newcol_d = {1'b0, col_q};
        fv_d     = 1'b0;
        state_d  = CHECK;
      end
      CHECK: begin
        // winner is evaluated on the board that landed last cycle
        if (winner != 7'h7F) state_d = WIN;
        else if ((occ[0] & COL_MASK) == COL_MASK) state_d = DRAW;
        else begin
          turn_d  = !turn_q;
          state_d = IDLE;
        end
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      red_q    <= '0;
      grn_q    <= '0;
      cur_q    <= MID_COL;
      col_q    <= 4'd0;
      row_q    <= 4'd0;
      newrow_q <= 5'd0;
      newcol_q <= 5'd0;
      turn_q   <= 1'b1;
      fv_q     <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      red_q    <= red_d;
      grn_q    <= grn_d;
      cur_q    <= cur_d;
      col_q    <= col_d;
      row_q    <= row_d;
      newrow_q <= newrow_d;
      newcol_q <= newcol_d;
      turn_q   <= turn_d;
      fv_q     <= fv_d;
      cnt_q    <= cnt_d;
    end
  end
  assign red        = red_q;
  assign grn        = grn_q;
  assign newrow     = newrow_q;
  assign newcolumn  = newcol_q;
  assign cursor_col = cur_q;
  assign turn_grn   = turn_q;
  assign fall_valid = fv_q;
  assign fall_row   = row_q;
  assign busy       = state_q != IDLE;
  assign game_over  = (state_q == WIN) || (state_q == DRAW);
  assign draw       = state_q == DRAW;
endmodule

// File: tb/tb_token_drop_ctrl.sv
// tb_token_drop_ctrl: scoreboard bench for token_drop_ctrl on an 8x8 board, FALL_TICKS=2.
module tb_token_drop_ctrl;
  localparam int FT = 2;
  logic clk = 0, reset = 1, move_left = 0, move_right = 0, drop = 0;
  logic [6:0] winner = 7'h7F;
  logic [15:0][15:0] red, grn, mr, mg;
  logic [4:0] newrow, newcolumn;
  logic [3:0] cursor_col, fall_row, mcur;
  logic turn_grn, fall_valid, busy, game_over, draw, mturn;
  int checks = 0, errors = 0;
  typedef struct {logic acc; int row; int cyc; logic turn; logic go; logic drw;} exp_t;
  exp_t sb[$];
  token_drop_ctrl #(.NROWS(8), .NCOLS(8), .FALL_TICKS(FT)) dut (
    .clk(clk), .reset(reset), .move_left(move_left), .move_right(move_right), .drop(drop),
    .winner(winner), .red(red), .grn(grn), .newrow(newrow), .newcolumn(newcolumn),
    .cursor_col(cursor_col), .turn_grn(turn_grn), .fall_valid(fall_valid), .fall_row(fall_row),
    .busy(busy), .game_over(game_over), .draw(draw)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    mr = '0;
    mg = '0;
    mcur = 4'd4;
    mturn = 1'b1;
  endtask
  task automatic rst_dut();
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    model_reset();
  endtask
  task automatic mv(input logic l, input logic r);
    if (l && !r) mcur = (mcur == 0) ? 4'd7 : mcur - 4'd1;
    if (r && !l) mcur = (mcur == 7) ? 4'd0 : mcur + 4'd1;
    @(negedge clk) begin move_left = l; move_right = r; end
    @(negedge clk) begin move_left = 0; move_right = 0; end
    chk("cursor", cursor_col, mcur);
  endtask
  task automatic do_drop(input logic win);
    exp_t e;
    int n, r;
    e = '{default: 0};
    e.acc = !(mr[0][mcur] | mg[0][mcur]);
    if (e.acc) begin
      r = 7;
      while (mr[r][mcur] | mg[r][mcur]) r--;
      e.row = r;
      e.cyc = (r + 1) * FT + 2;
      if (mturn) mg[r][mcur] = 1'b1;
      else mr[r][mcur] = 1'b1;
      e.drw = !win && (((mr[0] | mg[0]) & 16'hFF) == 16'hFF);
      e.go = win || e.drw;
      if (!e.go) mturn = !mturn;
    end
    e.turn = mturn;
    sb.push_back(e);
    @(negedge clk) drop = 1;
    @(negedge clk) drop = 0;
    if (busy) begin
      chk("fall_valid", fall_valid, 1);
      chk("fall_row0", fall_row, 0);
    end
    n = 0;
    while (busy && !game_over && n < 100) begin
      if (win && n == e.cyc - 1) winner = 7'h79;
      @(negedge clk);
      n++;
    end
    winner = 7'h7F;
    e = sb.pop_front();
    chk("busy_cycles", n, e.acc ? e.cyc : 0);
    if (e.acc) begin
      chk("newrow", newrow, e.row);
      chk("newcolumn", newcolumn, mcur);
      chk("fall_valid_end", fall_valid, 0);
    end
    chk("turn", turn_grn, e.turn);
    chk("game_over", game_over, e.go);
    chk("draw", draw, e.drw);
    chk("red", red, mr);
    chk("grn", grn, mg);
  endtask
  initial begin
    model_reset();
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    chk("rst_red", red, 0);
    chk("rst_grn", grn, 0);
    chk("rst_cursor", cursor_col, 4);
    chk("rst_turn", turn_grn, 1);
    chk("rst_busy", busy, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_fall_valid", fall_valid, 0);
    chk("rst_newrow", newrow, 0);
    for (int i = 0; i < 9; i++) do_drop(1'b0);
    for (int i = 0; i < 5; i++) mv(1'b1, 1'b0);
    chk("wrap_left", cursor_col, 7);
    mv(1'b1, 1'b1);
    mv(1'b0, 1'b1);
    mv(1'b1, 1'b0);
    do_drop(1'b0);
    do_drop(1'b0);
    do_drop(1'b1);
    @(negedge clk) begin drop = 1; move_left = 1; end
    @(negedge clk) begin drop = 0; move_left = 0; move_right = 1; end
    @(negedge clk) move_right = 0;
    chk("win_hold_red", red, mr);
    chk("win_hold_grn", grn, mg);
    chk("win_hold_cursor", cursor_col, mcur);
    chk("win_hold_turn", turn_grn, 1);
    chk("win_hold_go", game_over, 1);
    rst_dut();
    @(negedge clk) drop = 1;
    @(negedge clk) drop = 0;
    repeat (3) @(negedge clk);
    chk("mid_fall_busy", busy, 1);
    reset = 1;
    @(negedge clk);
    chk("midrst_fall_valid", fall_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_board", red | grn, 0);
    chk("midrst_cursor", cursor_col, 4);
    reset = 0;
    model_reset();
    for (int i = 0; i < 4; i++) mv(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 8; i++) do_drop(1'b0);
      if (c < 7) mv(1'b0, 1'b1);
    end
    chk("draw_final", draw, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
